instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 50 +++++
 rtl/instr_encoder_pack.sv | 100 ++++++++++
 rtl/instr_encoder.sv | 174 +++++++++++++++++
 tb/tb_instr_encoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_pkg
// Purpose  : Shared encoding definitions for the instruction encoder and the
//            matching decoder: request kinds, data-processing command codes,
//            the "always" condition code and the major opcode field values.
// Config   : INSTR_ENCODER_LSL_EN (used by instr_pack) enables the LSL command.
// Revision : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

  // Request kinds; encodings 5..7 are illegal.
  typedef enum logic [2:0] {
    KIND_DP_REG = 3'd0,
    KIND_DP_IMM = 3'd1,
    KIND_LDR    = 3'd2,
    KIND_STR    = 3'd3,
    KIND_B      = 3'd4
  } req_kind_e;

  // Data-processing command codes
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_LSL = 4'b1101;

  // Condition "always"
  localparam logic [3:0] COND_AL = 4'hE;

  // Major opcode field [27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Fixed funct bits: memory funct = {0,1,1,0,0,L}; branch funct[5:4] = 2'b10
  localparam logic [4:0] FUNCT_MEM_HI = 5'b01100;
  localparam logic [1:0] FUNCT_BR_HI  = 2'b10;

  // Compare-type commands only set flags: S is forced on and Rd is zeroed.
  function automatic logic cmd_is_compare(input logic [3:0] cmd);
    return (cmd == CMD_CMP) || (cmd == CMD_TST) || (cmd == CMD_CMN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// ============================================================================
// Module   : instr_pack
// Purpose  : Combinational instruction packer. Forms the 32-bit word
//            {cond, op, funct, Rn, Rd, src2} from the captured request fields
//            and flags requests that cannot be encoded.
// Ports    : i_kind/i_cond/i_cmd/i_s/i_rd/i_rn/i_rm/i_imm/i_target - request
//            i_pc   - address the word will be written to (branch base)
//            o_word - encoded instruction, o_err - request is not encodable
// Config   : INSTR_ENCODER_LSL_EN - when defined, cmd 1101 (LSL) is legal.
// Revision : 1.0 - initial release
// ============================================================================
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [3:0]  i_cond,
  input  logic [3:0]  i_cmd,
  input  logic        i_s,
  input  logic [3:0]  i_rd,
  input  logic [3:0]  i_rn,
  input  logic [3:0]  i_rm,
  input  logic [11:0] i_imm,
  input  logic [31:0] i_target,
  input  logic [31:0] i_pc,
  output logic [31:0] o_word,
  output logic        o_err
);

  logic        w_cmp;
  logic        w_s;
  logic [3:0]  w_rd;
  logic        w_cmd_ok;
  logic [31:0] w_diff;
  logic        w_off_ok;
  logic        w_unused_diff_lo;
  req_kind_e   w_kind;

  assign w_kind = req_kind_e'(i_kind);
  assign w_cmp  = cmd_is_compare(i_cmd);
  assign w_s    = i_s | w_cmp;
  assign w_rd   = w_cmp ? 4'h0 : i_rd;

  // Branch offset is relative to the write address + 8. The word offset
  // (diff >>> 2) fits in signed 24 bits exactly when diff[31:25] are all
  // copies of the sign bit diff[25].
  assign w_diff   = i_target - (i_pc + 32'd8);
  assign w_off_ok = (w_diff[31:25] == {7{w_diff[25]}});
  // Low difference bits are discarded by the shift.
  assign w_unused_diff_lo = ^w_diff[1:0];

  always_comb begin
    w_cmd_ok = 1'b0;
    case (i_cmd)
      CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR,
      CMD_CMP, CMD_TST, CMD_CMN, CMD_ADC: w_cmd_ok = 1'b1;
`ifdef INSTR_ENCODER_LSL_EN
      CMD_LSL:                            w_cmd_ok = 1'b1;
`endif
      default:                            w_cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    o_word = 32'h0;
    o_err  = 1'b0;
    case (w_kind)
      KIND_DP_REG: begin
        o_err  = ~w_cmd_ok;
        o_word = {i_cond, OP_DP, 1'b0, i_cmd, w_s, i_rn, w_rd, 8'h00, i_rm};
`ifdef INSTR_ENCODER_LSL_EN
        // LSL: Rn unused (zero), shift amount sits above the Rm field.
        if (i_cmd == CMD_LSL) begin
          o_word = {i_cond, OP_DP, 1'b0, i_cmd, w_s, 4'h0, w_rd,
                    i_imm[4:0], 2'b00, 1'b0, i_rm};
        end
`endif
      end
      KIND_DP_IMM: begin
        o_err  = ~w_cmd_ok;
        o_word = {i_cond, OP_DP, 1'b1, i_cmd, w_s, i_rn, w_rd, i_imm};
      end
      KIND_LDR: begin
        o_word = {i_cond, OP_MEM, FUNCT_MEM_HI, 1'b1, i_rn, i_rd, i_imm};
      end
      KIND_STR: begin
        o_word = {i_cond, OP_MEM, FUNCT_MEM_HI, 1'b0, i_rn, i_rd, i_imm};
      end
      KIND_B: begin
        o_err  = (i_target[1:0] != 2'b00) | ~w_off_ok;
        o_word = {i_cond, OP_BR, FUNCT_BR_HI, w_diff[25:2]};
      end
      default: begin
        o_err  = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Accepts instruction requests, encodes them into 32-bit words and
//            writes them to consecutive instruction-memory addresses.
//            IDLE -> ENC (encode/check) -> WR (hold write until mem_ready).
// Ports    : clk, reset (async, active-high)
//            req_valid/req_ready, req_* fields   - request channel
//            base_load/base_addr                 - load next write address
//            mem_we/mem_addr/mem_wdata/mem_ready - memory write port
//            wr_count (saturating), err (sticky), busy
// Config   : INSTR_ENCODER_LSL_EN - enables LSL encoding (see instr_pack).
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [3:0]  req_cond,
  input  logic [3:0]  req_cmd,
  input  logic        req_s,
  input  logic [3:0]  req_rd,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rm,
  input  logic [11:0] req_imm,
  input  logic [31:0] req_target,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic [15:0] wr_count,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  state_e      r_state;
  logic        r_req_ready;
  logic        r_busy;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [15:0] r_wr_count;
  logic        r_err;

  logic [2:0]  r_kind;
  logic [3:0]  r_cond;
  logic [3:0]  r_cmd;
  logic        r_s;
  logic [3:0]  r_rd;
  logic [3:0]  r_rn;
  logic [3:0]  r_rm;
  logic [11:0] r_imm;
  logic [31:0] r_target;

  logic [31:0] w_word;
  logic        w_pack_err;

  // r_mem_addr is the address this request will be written to, so it is
  // also the branch base for the packer.
  instr_pack u_pack (
    .i_kind   (r_kind),
    .i_cond   (r_cond),
    .i_cmd    (r_cmd),
    .i_s      (r_s),
    .i_rd     (r_rd),
    .i_rn     (r_rn),
    .i_rm     (r_rm),
    .i_imm    (r_imm),
    .i_target (r_target),
    .i_pc     (r_mem_addr),
    .o_word   (w_word),
    .o_err    (w_pack_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_wr_count  <= 16'h0;
      r_err       <= 1'b0;
      r_kind      <= 3'h0;
      r_cond      <= 4'h0;
      r_cmd       <= 4'h0;
      r_s         <= 1'b0;
      r_rd        <= 4'h0;
      r_rn        <= 4'h0;
      r_rm        <= 4'h0;
      r_imm       <= 12'h0;
      r_target    <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          // A same-cycle accept sees the loaded base because ENC reads
          // r_mem_addr one cycle later.
          if (base_load) begin
            r_mem_addr <= base_addr;
          end
          if (req_valid && r_req_ready) begin
            r_kind      <= req_kind;
            r_cond      <= req_cond;
            r_cmd       <= req_cmd;
            r_s         <= req_s;
            r_rd        <= req_rd;
            r_rn        <= req_rn;
            r_rm        <= req_rm;
            r_imm       <= req_imm;
            r_target    <= req_target;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_ENC;
          end
        end
        ST_ENC: begin
          if (w_pack_err) begin
            r_err       <= 1'b1;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_mem_wdata <= w_word;
            r_mem_we    <= 1'b1;
            r_state     <= ST_WR;
          end
        end
        ST_WR: begin
          if (mem_ready) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= r_mem_addr + 32'd4;
            if (r_wr_count != 16'hFFFF) begin
              r_wr_count <= r_wr_count + 16'd1;
            end
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_mem_we    <= 1'b0;
          r_req_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wr_count  = r_wr_count;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder: directed vector table,
//            hand-written stall/reset sequences and randomized requests
//            checked against a behavioural encoding model.
// Config   : honours INSTR_ENCODER_LSL_EN for LSL expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

`ifdef INSTR_ENCODER_LSL_EN
  localparam bit LSL_EN = 1'b1;
`else
  localparam bit LSL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [3:0]  req_cond;
  logic [3:0]  req_cmd;
  logic        req_s;
  logic [3:0]  req_rd;
  logic [3:0]  req_rn;
  logic [3:0]  req_rm;
  logic [11:0] req_imm;
  logic [31:0] req_target;
  logic        base_load;
  logic [31:0] base_addr;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] wr_count;
  logic        err;
  logic        busy;

  instr_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_cond   (req_cond),
    .req_cmd    (req_cmd),
    .req_s      (req_s),
    .req_rd     (req_rd),
    .req_rn     (req_rn),
    .req_rm     (req_rm),
    .req_imm    (req_imm),
    .req_target (req_target),
    .base_load  (base_load),
    .base_addr  (base_addr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .wr_count   (wr_count),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [11:0] imm;
    logic [31:0] target;
    logic        bl;
    logic [31:0] ba;
    int          stall;
    bit          noise;
    logic [31:0] exp_word;
    bit          exp_err;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: next write address, words written, sticky error
  logic [31:0] m_addr = 32'h0;
  logic [15:0] m_cnt  = 16'h0;
  bit          m_err  = 1'b0;

  task automatic chk(input string tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got 0x%08h, expected 0x%08h", tag, name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] kind, input logic [3:0] cmd,
                              input logic s, input logic [3:0] rd,
                              input logic [3:0] rn, input logic [3:0] rm,
                              input logic [11:0] imm, input logic [31:0] target,
                              input logic bl, input logic [31:0] ba,
                              input int stall, input bit noise,
                              input logic [31:0] w, input bit e);
    vec_t v;
    v.kind = kind; v.cond = 4'hE; v.cmd = cmd; v.s = s;
    v.rd = rd; v.rn = rn; v.rm = rm; v.imm = imm; v.target = target;
    v.bl = bl; v.ba = ba; v.stall = stall; v.noise = noise;
    v.exp_word = w; v.exp_err = e;
    return v;
  endfunction

  // Behavioural encoder: builds the word from field values with shifts and
  // sums, the branch offset with signed integer arithmetic.
  function automatic void model(input vec_t v, input logic [31:0] pc,
                                output logic [31:0] w, output bit e);
    int unsigned op, funct, rn, rd, src2;
    int          d, off;
    bit          is_cmp, legal;
    e = 1'b0; op = 0; funct = 0; rn = v.rn; rd = v.rd; src2 = 0;
    if (v.kind <= 3'd1) begin
      legal  = (v.cmd inside {4'h0, 4'h2, 4'h4, 4'h5, 4'h8, 4'hA, 4'hB, 4'hC}) ||
               (LSL_EN && v.cmd == 4'hD);
      is_cmp = v.cmd inside {4'h8, 4'hA, 4'hB};
      e      = !legal;
      funct  = v.kind * 32 + v.cmd * 2 + ((v.s || is_cmp) ? 1 : 0);
      if (is_cmp) rd = 0;
      if (v.kind == 3'd1) src2 = v.imm;
      else if (v.cmd == 4'hD) begin
        rn   = 0;
        src2 = v.imm[4:0] * 128 + v.rm;
      end else src2 = v.rm;
    end else if (v.kind == 3'd2 || v.kind == 3'd3) begin
      op    = 1;
      funct = 24 + ((v.kind == 3'd2) ? 1 : 0);
      src2  = v.imm;
    end else if (v.kind == 3'd4) begin
      d   = int'(v.target - pc - 32'd8);
      off = d >>> 2;
      e   = (v.target % 4 != 0) || (off < -(2**23)) || (off >= 2**23);
      w   = (int'(v.cond) << 28) + (2 << 26) + (2 << 24) + (off & 32'h00FF_FFFF);
      return;
    end else begin
      e = 1'b1;
    end
    w = (int'(v.cond) << 28) + (op << 26) + (funct << 20) + (rn << 16) + (rd << 12) + src2;
  endfunction

  task automatic run_txn(input vec_t v, input logic [31:0] ew, input bit ee,
                         input string tag);
    int          n, cyc, held, first_cyc;
    bit          seen;
    logic [31:0] ca, cd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk(tag, "ready", 32'(req_ready), 32'd1);
    req_kind = v.kind; req_cond = v.cond; req_cmd = v.cmd; req_s = v.s;
    req_rd = v.rd; req_rn = v.rn; req_rm = v.rm; req_imm = v.imm;
    req_target = v.target; base_load = v.bl; base_addr = v.ba;
    req_valid = 1'b1;
    if (v.bl) m_addr = v.ba;
    mem_ready = (v.stall == 0);
    @(negedge clk);
    req_valid = 1'b0; base_load = 1'b0;
    cyc = 0; held = 0; seen = 1'b0; first_cyc = -1; ca = 32'h0; cd = 32'h0;
    while (busy && cyc < 60) begin
      if (v.noise) begin
        base_load = 1'b1;          // must be ignored while busy
        base_addr = 32'hDEAD_0000;
      end
      if (mem_we) begin
        if (!seen) begin
          seen = 1'b1; first_cyc = cyc; ca = mem_addr; cd = mem_wdata;
        end else begin
          chk(tag, "hold_addr", mem_addr, ca);
          chk(tag, "hold_data", mem_wdata, cd);
        end
        if (held >= v.stall) mem_ready = 1'b1;
        held++;
      end
      @(negedge clk); cyc++;
    end
    base_load = 1'b0;
    mem_ready = 1'b0;
    chk(tag, "done", 32'(busy), 32'd0);
    if (ee) begin
      m_err = 1'b1;
      chk(tag, "no_write", 32'(seen), 32'd0);
    end else begin
      chk(tag, "wrote", 32'(seen), 32'd1);
      chk(tag, "latency", first_cyc, 32'd1);
      chk(tag, "wr_addr", ca, m_addr);
      chk(tag, "wr_data", cd, ew);
      m_addr = m_addr + 32'd4;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    chk(tag, "err", 32'(err), 32'(m_err));
    chk(tag, "mem_addr", mem_addr, m_addr);
    chk(tag, "wr_count", 32'(wr_count), 32'(m_cnt));
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, "mem_we", 32'(mem_we), 32'd0);
    chk(tag, "mem_addr", mem_addr, 32'd0);
    chk(tag, "mem_wdata", mem_wdata, 32'd0);
    chk(tag, "wr_count", 32'(wr_count), 32'd0);
    chk(tag, "err", 32'(err), 32'd0);
    chk(tag, "busy", 32'(busy), 32'd0);
    chk(tag, "req_ready", 32'(req_ready), 32'd0);
  endtask

  vec_t        tbl [0:16];
  logic [3:0]  legal_cmds [0:8] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD};

  initial begin
    vec_t        v;
    logic [31:0] ew, pc;
    bit          ee;
    int          n;

    tbl[0]  = mk(3'd0, 4'h4, 1'b0, 4'd1, 4'd2, 4'd3, 12'h000, 32'h0, 1'b1, 32'h0, 0, 1'b0, 32'hE082_1003, 1'b0);
    tbl[1]  = mk(3'd1, 4'h2, 1'b1, 4'd4, 4'd4, 4'd0, 12'h001, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'hE254_4001, 1'b0);
    tbl[2]  = mk(3'd1, 4'hA, 1'b0, 4'd7, 4'd1, 4'd0, 12'h000, 32'h0, 1'b0, 32'h0, 1, 1'b0, 32'hE351_0000, 1'b0);
    tbl[3]  = mk(3'd2, 4'h0, 1'b0, 4'd0, 4'd1, 4'd0, 12'h004, 32'h0, 1'b1, 32'h0, 0, 1'b0, 32'hE591_0004, 1'b0);
    tbl[4]  = mk(3'd3, 4'h0, 1'b0, 4'd0, 4'd1, 4'd0, 12'h004, 32'h0, 1'b0, 32'h0, 5, 1'b0, 32'hE581_0004, 1'b0);
    tbl[5]  = mk(3'd4, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h100, 1'b1, 32'h100, 0, 1'b0, 32'hEAFF_FFFE, 1'b0);
    tbl[6]  = mk(3'd0, 4'hC, 1'b1, 4'd5, 4'd6, 4'd7, 12'h000, 32'h0, 1'b0, 32'h0, 2, 1'b1, 32'hE196_5007, 1'b0);
    tbl[7]  = mk(3'd0, 4'h8, 1'b0, 4'd9, 4'd3, 4'd4, 12'h000, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'hE113_0004, 1'b0);
    tbl[8]  = mk(3'd4, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h0, 1'b1, 32'h01FF_FFF8, 0, 1'b0, 32'hEA80_0000, 1'b0);
    tbl[9]  = mk(3'd4, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h0200_0004, 1'b1, 32'h0, 0, 1'b0, 32'hEA7F_FFFF, 1'b0);
    tbl[10] = mk(3'd0, 4'h5, 1'b0, 4'd1, 4'd1, 4'd1, 12'h000, 32'h0, 1'b1, 32'hFFFF_FFFC, 1, 1'b1, 32'hE0A1_1001, 1'b0);
    tbl[11] = mk(3'd0, 4'h4, 1'b0, 4'd1, 4'd2, 4'd3, 12'h000, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'hE082_1003, 1'b0);
    tbl[12] = mk(3'd0, 4'hD, 1'b0, 4'd2, 4'd5, 4'd3, 12'h004, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'hE1A0_2203, !LSL_EN);
    tbl[13] = mk(3'd4, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h102, 1'b1, 32'h100, 0, 1'b0, 32'h0, 1'b1);
    tbl[14] = mk(3'd4, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h0200_0008, 1'b1, 32'h0, 0, 1'b0, 32'h0, 1'b1);
    tbl[15] = mk(3'd5, 4'h4, 1'b0, 4'd1, 4'd2, 4'd3, 12'h000, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'h0, 1'b1);
    tbl[16] = mk(3'd0, 4'h1, 1'b0, 4'd1, 4'd2, 4'd3, 12'h000, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1);

    reset = 1'b1; req_valid = 1'b0; req_kind = 3'd0; req_cond = 4'h0; req_cmd = 4'h0;
    req_s = 1'b0; req_rd = 4'h0; req_rn = 4'h0; req_rm = 4'h0; req_imm = 12'h0;
    req_target = 32'h0; base_load = 1'b0; base_addr = 32'h0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // Directed table
    for (int i = 0; i <= 16; i++) begin
      run_txn(tbl[i], tbl[i].exp_word, tbl[i].exp_err, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a stalled write
    v = tbl[0];
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_kind = v.kind; req_cond = v.cond; req_cmd = v.cmd; req_s = v.s;
    req_rd = v.rd; req_rn = v.rn; req_rm = v.rm; req_imm = v.imm;
    req_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 10) begin @(negedge clk); n++; end
    chk("midwr", "mem_we_before", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1 chk_zero("midwr");
    @(negedge clk);
    reset = 1'b0;
    m_addr = 32'h0; m_cnt = 16'h0; m_err = 1'b0;

    // Randomized requests against the model
    for (int i = 0; i < 150; i++) begin
      v.kind   = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      v.cond   = 4'($urandom);
      v.cmd    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : legal_cmds[$urandom_range(0, 8)];
      v.s      = 1'($urandom);
      v.rd     = 4'($urandom);
      v.rn     = 4'($urandom);
      v.rm     = 4'($urandom);
      v.imm    = 12'($urandom);
      v.bl     = ($urandom_range(0, 7) == 0);
      v.ba     = $urandom & 32'hFFFF_FFFC;
      v.stall  = $urandom_range(0, 3);
      v.noise  = ($urandom_range(0, 3) == 0);
      pc       = v.bl ? v.ba : m_addr;
      case ($urandom_range(0, 3))
        0:       v.target = pc + 32'(($urandom_range(0, 2000) - 1000) * 4);
        1:       v.target = $urandom & 32'hFFFF_FFFC;
        2:       v.target = $urandom;
        default: v.target = pc + 32'd8;
      endcase
      model(v, pc, ew, ee);
      run_txn(v, ew, ee, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
